// File: rtl/lb_rr_dispatch_pkg.sv
// ---------------------------------------------------------------------------
// lb_rr_dispatch_pkg
//   Shared definitions for the round-robin ingress dispatcher:
//   - width derivation helpers for the core index, slot index and
//     {core, tag} descriptor fields
//   - dispatcher FSM state encoding
// ---------------------------------------------------------------------------
package lb_rr_dispatch_pkg;

  // Core index width; a single-core build still needs a 1-bit index.
  function automatic int calc_core_id_width(input int core_count);
    return (core_count > 1) ? $clog2(core_count) : 1;
  endfunction

  // Slot index width must also encode the value SLOT_COUNT itself.
  function automatic int calc_slot_width(input int slot_count);
    return $clog2(slot_count + 1);
  endfunction

  // Tag field is never narrower than 5 bits.
  function automatic int calc_tag_width(input int slot_width);
    return (slot_width > 5) ? slot_width : 5;
  endfunction

  typedef enum logic [1:0] {
    ST_PICK = 2'd0,  // choose the next eligible core
    ST_ARM  = 2'd1,  // core chosen, waiting for a packet to pop a descriptor
    ST_PASS = 2'd2   // forwarding the tagged packet
  } state_e;

endpackage

// File: rtl/lb_rr_dispatch_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin selector. Returns the lowest eligible index
//   strictly greater than last_core, wrapping to the lowest eligible index
//   overall. When last_core is the only eligible core it is returned again.
//
// Ports:
//   elig       in   CORE_COUNT     per-core eligibility
//   last_core  in   CORE_ID_WIDTH  most recently served core
//   idx        out  CORE_ID_WIDTH  selected core (don't-care when !valid)
//   valid      out  1              at least one core is eligible
// ---------------------------------------------------------------------------
module rr_pick
  import lb_rr_dispatch_pkg::*;
#(
  parameter int CORE_COUNT    = 8,
  parameter int CORE_ID_WIDTH = calc_core_id_width(CORE_COUNT)
) (
  input  logic [CORE_COUNT-1:0]    elig,
  input  logic [CORE_ID_WIDTH-1:0] last_core,
  output logic [CORE_ID_WIDTH-1:0] idx,
  output logic                     valid
);

  always_comb begin
    // NOTE: every output gets a default before any conditional assignment,
    // so no path through the block leaves a value held (no latch).
    idx   = '0;
    valid = |elig;
    // Descending scans so the last hit is the lowest index. The first scan
    // is the wrap-around fallback; the second overrides it with the lowest
    // eligible index above last_core, if there is one.
    for (int i = CORE_COUNT - 1; i >= 0; i--) begin
      if (elig[i]) idx = CORE_ID_WIDTH'(i);
    end
    for (int i = CORE_COUNT - 1; i >= 0; i--) begin
      if (elig[i] && (i > int'(last_core))) idx = CORE_ID_WIDTH'(i);
    end
  end

endmodule

// File: rtl/lb_rr_dispatch.sv
// ---------------------------------------------------------------------------
// lb_rr_dispatch
//   Ingress dispatcher ahead of the load-balancer slot controller. For each
//   packet it picks the next enabled core with a free slot (round-robin),
//   pops that core's head descriptor and stamps it on every beat of the
//   packet as tdest (core) / tuser ({core, tag}).
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   s_axis_t{data,keep,valid,
//            ready,last}         packet input stream
//   m_axis_t{data,keep,valid,
//            ready,last,dest,
//            user}               tagged packet output stream
//   enabled_cores                per-core enable
//   slot_valids                  per-core free-slot-available flag
//   selected_core                core whose head descriptor is presented
//   desc_pop                     one-cycle pop of selected_core's head slot
//   desc_data                    head descriptor of selected_core (comb)
//   pkt_count                    packets fully dispatched (wraps)
//   stall_count                  cycles stalled for lack of an eligible core
// ---------------------------------------------------------------------------
module lb_rr_dispatch
  import lb_rr_dispatch_pkg::*;
#(
  parameter int CORE_COUNT    = 8,
  parameter int SLOT_COUNT    = 32,
  parameter int DATA_WIDTH    = 64,
  parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
  parameter int CORE_ID_WIDTH = calc_core_id_width(CORE_COUNT),
  parameter int SLOT_WIDTH    = calc_slot_width(SLOT_COUNT),
  parameter int TAG_WIDTH     = calc_tag_width(SLOT_WIDTH),
  parameter int ID_TAG_WIDTH  = CORE_ID_WIDTH + TAG_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,

  input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]    s_axis_tkeep,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic                     s_axis_tlast,

  output logic [DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]    m_axis_tkeep,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast,
  output logic [CORE_ID_WIDTH-1:0] m_axis_tdest,
  output logic [ID_TAG_WIDTH-1:0]  m_axis_tuser,

  input  logic [CORE_COUNT-1:0]    enabled_cores,
  input  logic [CORE_COUNT-1:0]    slot_valids,
  output logic [CORE_ID_WIDTH-1:0] selected_core,
  output logic                     desc_pop,
  input  logic [ID_TAG_WIDTH-1:0]  desc_data,

  output logic [31:0]              pkt_count,
  output logic [31:0]              stall_count
);

  state_e                   state, state_next;
  logic [CORE_COUNT-1:0]    elig;
  logic [CORE_ID_WIDTH-1:0] last_core;
  logic [ID_TAG_WIDTH-1:0]  tag_r;
  logic [CORE_ID_WIDTH-1:0] pick_idx;
  logic                     pick_valid;
  logic                     stall_cycle;
  logic                     pkt_done;

  assign elig = enabled_cores & slot_valids;

  rr_pick #(
    .CORE_COUNT   (CORE_COUNT),
    .CORE_ID_WIDTH(CORE_ID_WIDTH)
  ) u_rr_pick (
    .elig     (elig),
    .last_core(last_core),
    .idx      (pick_idx),
    .valid    (pick_valid)
  );

  // Payload is a pure passthrough; only valid/ready are gated by the FSM.
  assign m_axis_tdata = s_axis_tdata;
  assign m_axis_tkeep = s_axis_tkeep;
  assign m_axis_tlast = s_axis_tlast;
  assign m_axis_tdest = tag_r[ID_TAG_WIDTH-1 -: CORE_ID_WIDTH];
  assign m_axis_tuser = tag_r;

  always_comb begin
    state_next    = state;
    desc_pop      = 1'b0;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    stall_cycle   = 1'b0;
    pkt_done      = 1'b0;
    unique case (state)
      ST_PICK: begin
        if (pick_valid) state_next  = ST_ARM;
        else            stall_cycle = 1'b1;
      end
      ST_ARM: begin
        if (!elig[selected_core]) begin
          // Slot taken elsewhere or core disabled since the pick: re-pick.
          state_next  = ST_PICK;
          stall_cycle = s_axis_tvalid && (elig == '0);
        end else if (s_axis_tvalid) begin
          // Pop only once the packet is actually present, so an idle input
          // never consumes a slot. The first beat is forwarded from PASS.
          desc_pop   = 1'b1;
          state_next = ST_PASS;
        end
      end
      ST_PASS: begin
        m_axis_tvalid = s_axis_tvalid;
        s_axis_tready = m_axis_tready;
        if (s_axis_tvalid && m_axis_tready && s_axis_tlast) begin
          pkt_done   = 1'b1;
          state_next = ST_PICK;
        end
      end
      default: state_next = ST_PICK;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_PICK;
      selected_core <= '0;
      last_core     <= CORE_ID_WIDTH'(CORE_COUNT - 1);  // first pick is core 0
      tag_r         <= '0;
      pkt_count     <= '0;
      stall_count   <= '0;
    end else begin
      state <= state_next;
      if (state == ST_PICK && pick_valid) selected_core <= pick_idx;
      if (desc_pop)                       tag_r         <= desc_data;
      if (pkt_done) begin
        last_core <= selected_core;
        pkt_count <= pkt_count + 32'd1;
      end
      if (stall_cycle) stall_count <= stall_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_lb_rr_dispatch.sv
// ---------------------------------------------------------------------------
// tb_lb_rr_dispatch
//   Self-checking bench for lb_rr_dispatch. Emulates the slot controller
//   (per-core head tag counters advanced on desc_pop) and predicts the
//   destination of every packet with a round-robin reference model.
// ---------------------------------------------------------------------------
module tb_lb_rr_dispatch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] s_axis_tdata  = '0;
  logic [7:0]  s_axis_tkeep  = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        s_axis_tlast  = 1'b0;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tlast;
  logic [2:0]  m_axis_tdest;
  logic [8:0]  m_axis_tuser;
  logic [7:0]  enabled_cores = '0;
  logic [7:0]  slot_valids   = '0;
  logic [2:0]  selected_core;
  logic        desc_pop;
  logic [8:0]  desc_data;
  logic [31:0] pkt_count;
  logic [31:0] stall_count;

  always #5 clk = ~clk;

  lb_rr_dispatch dut (
    .clk          (clk),
    .rst          (rst),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tkeep (s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tlast (s_axis_tlast),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tkeep (m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tdest (m_axis_tdest),
    .m_axis_tuser (m_axis_tuser),
    .enabled_cores(enabled_cores),
    .slot_valids  (slot_valids),
    .selected_core(selected_core),
    .desc_pop     (desc_pop),
    .desc_data    (desc_data),
    .pkt_count    (pkt_count),
    .stall_count  (stall_count)
  );

  // Slot controller stand-in: each core hands out incrementing tags.
  logic [5:0] slot_head [8] = '{6'd0, 6'd9, 6'd18, 6'd27, 6'd36, 6'd45, 6'd54, 6'd63};
  assign desc_data = {selected_core, slot_head[selected_core]};
  always @(posedge clk) begin
    if (!rst && desc_pop) slot_head[selected_core] <= slot_head[selected_core] + 6'd1;
  end

  // Output monitor.
  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic [2:0]  dest;
    logic [8:0]  user;
  } beat_t;
  beat_t out_q [$];
  int    pop_count     = 0;
  int    last_pop_core = -1;

  always @(negedge clk) begin
    if (!rst) begin
      if (desc_pop) begin
        pop_count++;
        last_pop_core = int'(selected_core);
      end
      if (m_axis_tvalid && m_axis_tready)
        out_q.push_back('{m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tdest, m_axis_tuser});
    end
  end

  int checks = 0;
  int errors = 0;
  int model_last = 7;
  int pkts_since_reset = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: scan cores last+1, last+2, ... (mod 8) for the first eligible.
  function automatic int rr_model(input int last, input logic [7:0] elig);
    for (int k = 1; k <= 8; k++) begin
      int c = (last + k) % 8;
      if (elig[c]) return c;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    enabled_cores = '0;
    slot_valids   = '0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_last = 7;
    pkts_since_reset = 0;
  endtask

  // Sends one packet of nbeats (data base+i) and checks every output beat.
  task automatic send_packet(input string name, input logic [7:0] en, input logic [7:0] sl,
                             input int nbeats, input bit toggle, input logic [63:0] base,
                             input int exp_core);
    int         beat = 0;
    int         cyc  = 0;
    int         pops0;
    bit         hs;
    logic [2:0] ec;
    logic [8:0] exp_user;
    ec       = exp_core[2:0];
    exp_user = {ec, slot_head[ec]};
    pops0    = pop_count;
    out_q.delete();
    enabled_cores = en;
    slot_valids   = sl;
    m_axis_tready = 1'b1;
    s_axis_tvalid = 1'b1;
    while (beat < nbeats && cyc < 100) begin
      s_axis_tdata  = base + 64'(beat);
      s_axis_tkeep  = base[7:0] ^ 8'(beat);
      s_axis_tlast  = (beat == nbeats - 1);
      m_axis_tready = toggle ? ~m_axis_tready : 1'b1;
      @(negedge clk);
      hs = s_axis_tvalid && s_axis_tready;
      @(posedge clk);
      #1;
      if (hs) beat++;
      cyc++;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;
    check({name, "_beats_accepted"}, 64'(beat), 64'(nbeats));
    check({name, "_pops"}, 64'(pop_count - pops0), 64'd1);
    check({name, "_pop_core"}, 64'(last_pop_core), 64'(exp_core));
    check({name, "_out_beats"}, 64'(out_q.size()), 64'(nbeats));
    for (int i = 0; i < out_q.size() && i < nbeats; i++) begin
      check({name, "_data"}, out_q[i].data, base + 64'(i));
      check({name, "_keep_last"}, {out_q[i].keep, 7'd0, out_q[i].last},
            {base[7:0] ^ 8'(i), 7'd0, (i == nbeats - 1)});
      check({name, "_dest_user"}, {out_q[i].dest, out_q[i].user}, {ec, exp_user});
    end
    model_last = exp_core;
    pkts_since_reset++;
  endtask

  typedef struct {
    logic [7:0] en;
    logic [7:0] sl;
    int         beats;
    int         exp_core;
  } vec_t;

  initial begin
    vec_t       vecs [14];
    int         pops0;
    int         exp_c;
    int         beat;
    int         cyc;
    bit         hs;
    bit         ready_seen;
    logic [7:0] en, sl, el;

    vecs = '{
      '{8'h0f, 8'h0f, 1, 0}, '{8'h0f, 8'h0f, 1, 1},
      '{8'h0f, 8'h0f, 1, 2}, '{8'h0f, 8'h0f, 1, 3},
      '{8'h05, 8'hff, 1, 0}, '{8'h05, 8'hff, 2, 2},
      '{8'h05, 8'hff, 1, 0}, '{8'h05, 8'hff, 3, 2},
      '{8'hff, 8'h40, 1, 6}, '{8'h41, 8'hff, 2, 0},
      '{8'h40, 8'hff, 1, 6}, '{8'h40, 8'hff, 1, 6},
      '{8'h80, 8'h80, 2, 7}, '{8'hff, 8'h01, 1, 0}
    };

    // Reset state.
    do_reset();
    @(negedge clk);
    check("rst_tready", s_axis_tready, 1'b0);
    check("rst_tvalid", m_axis_tvalid, 1'b0);
    check("rst_pop", desc_pop, 1'b0);
    check("rst_sel", selected_core, 3'd0);
    check("rst_counts", {pkt_count, stall_count}, 64'd0);

    // No eligible core for 10 cycles with a packet waiting.
    do_reset();
    enabled_cores = 8'hff;
    slot_valids   = 8'h00;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 64'h55;
    ready_seen    = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (s_axis_tready || m_axis_tvalid) ready_seen = 1'b1;
      @(posedge clk);
      #1;
    end
    check("stall_tready", ready_seen, 1'b0);
    check("stall_count", stall_count, 32'd10);
    send_packet("stall_release", 8'hff, 8'h20, 1, 1'b0, 64'h5500, 5);

    // Table-driven round-robin sequence from a fresh reset.
    do_reset();
    pops0 = pop_count;
    for (int r = 0; r < 14; r++) begin
      send_packet($sformatf("vec%0d", r), vecs[r].en, vecs[r].sl, vecs[r].beats, 1'b0,
                  64'hA000_0000_0000_0000 + 64'(r * 16), vecs[r].exp_core);
      if (r == 3) begin
        check("vec_pkt_count4", pkt_count, 32'd4);
        check("vec_pops4", 64'(pop_count - pops0), 64'd4);
      end
    end

    // Slot disappears while ARMed: no pop, re-pick the next eligible core.
    exp_c = rr_model(model_last, 8'hff);
    enabled_cores = 8'hff;
    slot_valids   = 8'hff;
    s_axis_tvalid = 1'b0;
    pops0 = pop_count;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("arm_sel", selected_core, exp_c[2:0]);
    check("arm_tready", s_axis_tready, 1'b0);
    sl = 8'hff;
    sl[exp_c] = 1'b0;
    slot_valids   = sl;
    s_axis_tvalid = 1'b1;
    #1;
    check("arm_drop_pop", desc_pop, 1'b0);
    @(posedge clk);
    #1;
    check("arm_drop_pops", 64'(pop_count - pops0), 64'd0);
    send_packet("arm_drop", 8'hff, sl, 2, 1'b0, 64'hD000, rr_model(model_last, sl));

    // 5-beat packet under toggling backpressure.
    send_packet("bp5", 8'hff, 8'hff, 5, 1'b1, 64'hB0B0_0000, rr_model(model_last, 8'hff));

    // Randomized packets against the reference model.
    for (int n = 0; n < 30; n++) begin
      int b;
      en = 8'($urandom);
      sl = 8'($urandom);
      if ((en & sl) == 8'h00) begin
        b = $urandom_range(7);
        en[b] = 1'b1;
        sl[b] = 1'b1;
      end
      el = en & sl;
      send_packet($sformatf("rand%0d", n), en, sl, $urandom_range(4, 1), 1'($urandom_range(1)),
                  {32'($urandom), 32'($urandom)}, rr_model(model_last, el));
    end
    check("pkt_count_total", pkt_count, 32'(pkts_since_reset));

    // Reset on the third beat of a packet.
    enabled_cores = 8'hff;
    slot_valids   = 8'hff;
    m_axis_tready = 1'b1;
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = 1'b0;
    beat = 0;
    cyc  = 0;
    while (beat < 2 && cyc < 50) begin
      s_axis_tdata = 64'hE000 + 64'(beat);
      @(negedge clk);
      hs = s_axis_tvalid && s_axis_tready;
      @(posedge clk);
      #1;
      if (hs) beat++;
      cyc++;
    end
    check("midrst_two_beats", 64'(beat), 64'd2);
    s_axis_tdata = 64'hE002;
    rst = 1'b1;
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    @(negedge clk);
    check("midrst_tready", s_axis_tready, 1'b0);
    check("midrst_tvalid", m_axis_tvalid, 1'b0);
    check("midrst_counts", {pkt_count, stall_count}, 64'd0);
    check("midrst_sel", selected_core, 3'd0);
    rst = 1'b0;
    model_last = 7;
    pkts_since_reset = 0;
    send_packet("midrst_tail", 8'hff, 8'hff, 2, 1'b0, 64'hE003, 0);
    send_packet("midrst_next", 8'hff, 8'hff, 1, 1'b0, 64'hE100, 1);
    check("midrst_pkt_count", pkt_count, 32'(pkts_since_reset));
    check("midrst_stall", stall_count, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
